output_datapath: RTL
====================

OUTPUT_DATAPATH -- requirements
Module: output_datapath

Interface
REQ-001 SHALL have parameter N, default 4, meaning array dimension (N x N result matrix).
REQ-002 SHALL have parameter ELEM_W, default 32, meaning width of one result element C[r][c].
REQ-003 SHALL have parameter BEAT_W, default 64, meaning output beat width; exactly two elements per beat.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port c_in  input  N*N*ELEM_W  flattened result matrix; element C[r][c] at bits [(r*N+c)*ELEM_W +: ELEM_W].
REQ-007 SHALL have port load_result  input  1  one-cycle request to capture c_in (array compute complete).
REQ-008 SHALL have port dest_ready  input  1  downstream ready.
REQ-009 SHALL have port src_valid  output  1  data_out holds a valid beat.
REQ-010 SHALL have port data_out  output  BEAT_W  current beat.
REQ-011 SHALL have port tx_beat_done  output  1  high in any cycle where src_valid && dest_ready.
REQ-012 SHALL have port unload_done  output  1  one-cycle pulse after the final beat is accepted.
REQ-013 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-014 SHALL have port overrun  output  1  sticky flag: load_result seen while busy.

Function
REQ-015 SHALL implement states IDLE, SEND, DONE.
REQ-016 IDLE: on load_result SHALL capture all N*N elements of c_in into an internal buffer and go to SEND; otherwise remain in IDLE.
REQ-017 SHALL assert src_valid the cycle after the capturing edge (latency 1), presenting beat 0.
REQ-018 Beat order SHALL be row-major: beat b carries row b/2, columns 2*(b%2) and 2*(b%2)+1; lower column index in data_out[63:32], higher in [31:0]; N*N/2 = 8 beats per matrix.
REQ-019 SEND: src_valid SHALL stay high and data_out SHALL be stable while dest_ready is low (no beat dropped or changed under backpressure).
REQ-020 SEND: on src_valid && dest_ready, SHALL advance the beat counter; next beat valid in the following cycle, giving one beat per cycle when dest_ready is held high.
REQ-021 On acceptance of beat 7, SHALL deassert src_valid next cycle and enter DONE; counter wraps to 0.
REQ-022 DONE: unload_done SHALL be high for exactly that one cycle; next state IDLE unconditionally.
REQ-023 load_result in SEND or DONE SHALL be ignored (buffer unchanged, transfer continues) and SHALL set overrun until reset.
REQ-024 load_result in the same cycle DONE returns to IDLE SHALL be treated as an overrun (accepted only once state is IDLE).
REQ-025 dest_ready while src_valid is low SHALL have no effect.
REQ-026 data_out SHALL be driven from registers/buffer only; no combinational path from dest_ready to data_out or src_valid.

Reset
REQ-027 Reset SHALL force state IDLE, beat counter 0, src_valid 0, data_out 0, unload_done 0, overrun 0, buffer cleared, at any time, including mid-transfer.
REQ-028 After reset release, first beat SHALL appear only after a new load_result.

Structure
REQ-029 N, ELEM_W, BEAT_W, BEATS_PER_MATRIX (=8), and the state enum SHALL live in shared package systolic_pkg.
REQ-030 The beat counter (enable = src_valid && dest_ready, terminal-count pulse at 7, wrap to 0) SHALL be a sub-module named beat_counter.
REQ-031 Element buffer SHALL be 16 x ELEM_W registers written in parallel only on accepted load_result.

Verification
REQ-032 C[r][c]=16*r+c, load_result pulse, dest_ready=1 -> beats 0..7 on consecutive cycles: {0x0,0x1},{0x2,0x3},{0x10,0x11},...,{0x32,0x33}; unload_done one cycle after beat 7.
REQ-033 Same matrix, dest_ready low for 3 cycles during beat 2 -> src_valid held, data_out={0x10,0x11} stable, no tx_beat_done until ready returns.
REQ-034 load_result re-pulsed at beat 4 with c_in all 0xFFFFFFFF -> remaining beats still carry the original values; overrun=1 and stays 1.
REQ-035 reset asserted after beat 3 accepted -> same cycle src_valid=0, busy=0, overrun=0; new load gives beat 0 first.
REQ-036 Random dest_ready (50%) over 20 back-to-back matrices -> scoreboard matches all 160 beats in order, 20 unload_done pulses, overrun=0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array result path.
package systolic_pkg;

  localparam int N                = 4;
  localparam int ELEM_W           = 32;
  localparam int BEAT_W           = 64;
  localparam int BEATS_PER_MATRIX = (N * N) / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/output_datapath_beat_counter.sv
// Beat counter for the unload path: advances on each accepted beat,
// flags the terminal beat and wraps back to zero after it.
module beat_counter #(
  parameter int COUNT = systolic_pkg::BEATS_PER_MATRIX,
  parameter int CW    = $clog2(COUNT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_tc
);

  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  logic [CW-1:0] r_count;

  // Count accepted beats, returning to zero once the last beat goes out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_en) begin
      if (r_count == LAST) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_count = r_count;
  assign o_tc    = i_en && (r_count == LAST);

endmodule

// File: rtl/output_datapath.sv
// Result unload path: captures the finished N x N matrix in one cycle and
// streams it out row-major, two elements per beat, under valid/ready.
module output_datapath #(
  parameter int N      = systolic_pkg::N,
  parameter int ELEM_W = systolic_pkg::ELEM_W,
  parameter int BEAT_W = systolic_pkg::BEAT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N*N*ELEM_W-1:0] c_in,
  input  logic                  load_result,
  input  logic                  dest_ready,
  output logic                  src_valid,
  output logic [BEAT_W-1:0]     data_out,
  output logic                  tx_beat_done,
  output logic                  unload_done,
  output logic                  busy,
  output logic                  overrun
);

  import systolic_pkg::*;

  localparam int ELEMS = N * N;
  localparam int BEATS = ELEMS / 2;
  localparam int CW    = $clog2(BEATS);
  localparam int EW    = CW + 1;

  state_e              r_state;
  logic                r_srcValid;
  logic [BEAT_W-1:0]   r_dataOut;
  logic                r_unloadDone;
  logic                r_overrun;
  logic [ELEM_W-1:0]   r_buf [ELEMS];

  logic                w_accept;
  logic                w_capture;
  logic                w_lastBeat;
  logic [CW-1:0]       w_beatIdx;
  logic [CW-1:0]       w_nextIdx;
  logic [EW-1:0]       w_elemHi;
  logic [EW-1:0]       w_elemLo;
  logic [BEAT_W-1:0]   w_nextBeat;
  logic [BEAT_W-1:0]   w_firstBeat;

  assign w_accept  = r_srcValid && dest_ready;
  assign w_capture = load_result && (r_state == IDLE);

  beat_counter #(
    .COUNT (BEATS),
    .CW    (CW)
  ) u_beat_counter (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_accept),
    .o_count (w_beatIdx),
    .o_tc    (w_lastBeat)
  );

  // Beat k carries elements 2k and 2k+1 of the row-major matrix; the lower
  // column sits in the upper half of the beat.
  assign w_nextIdx   = w_beatIdx + 1'b1;
  assign w_elemHi    = {w_nextIdx, 1'b0};
  assign w_elemLo    = {w_nextIdx, 1'b1};
  assign w_nextBeat  = BEAT_W'({r_buf[w_elemHi], r_buf[w_elemLo]});
  assign w_firstBeat = BEAT_W'({c_in[0 +: ELEM_W], c_in[ELEM_W +: ELEM_W]});

  // Snapshot the whole result matrix when an idle capture is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ELEMS; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_capture) begin
      for (int i = 0; i < ELEMS; i++) begin
        r_buf[i] <= c_in[i*ELEM_W +: ELEM_W];
      end
    end
  end

  // Transfer FSM with registered valid, beat data, done pulse and overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_srcValid   <= 1'b0;
      r_dataOut    <= '0;
      r_unloadDone <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_unloadDone <= 1'b0;
      if (load_result && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (load_result) begin
            r_dataOut  <= w_firstBeat;
            r_srcValid <= 1'b1;
            r_state    <= SEND;
          end
        end
        SEND: begin
          if (w_accept) begin
            if (w_lastBeat) begin
              r_srcValid   <= 1'b0;
              r_dataOut    <= '0;
              r_unloadDone <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_dataOut <= w_nextBeat;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state    <= IDLE;
          r_srcValid <= 1'b0;
        end
      endcase
    end
  end

  assign src_valid    = r_srcValid;
  assign data_out     = r_dataOut;
  assign tx_beat_done = w_accept;
  assign unload_done  = r_unloadDone;
  assign busy         = (r_state != IDLE);
  assign overrun      = r_overrun;

endmodule
